// File: rtl/acc_exec_pkg.sv
// acc_exec_pkg: opcodes, reset value and FSM state type for the accumulator execute stage
package acc_exec_pkg;
    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LDA  = 3'd1;
    localparam logic [2:0] OP_LDB  = 3'd2;
    localparam logic [2:0] OP_ADD  = 3'd3;
    localparam logic [2:0] OP_SUB  = 3'd4;
    localparam logic [2:0] OP_CMP  = 3'd5;
    localparam logic [2:0] OP_ADDI = 3'd6;
    localparam logic [2:0] OP_OUT  = 3'd7;
    localparam logic [7:0] ACC_RESET = 8'h00;
    typedef enum logic [1:0] {IDLE, EXEC, EMIT} state_e;
endpackage

// File: rtl/acc_exec_if.sv
// acc_exec_if: command and output valid/ready ports of the execute stage
interface acc_exec_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    modport master (output cmd_valid, cmd_op, cmd_data, out_ready,
                    input  cmd_ready, out_valid, out_data);
    modport slave  (input  cmd_valid, cmd_op, cmd_data, out_ready,
                    output cmd_ready, out_valid, out_data);
endinterface

// File: rtl/acc_exec_unit_alu.sv
// ALU: 8-bit add/subtract; in subtract mode Cout reports borrow rather than carry
module ALU (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       sub,
    output logic [7:0] Sum,
    output logic       Cout,
    output logic       Ovf,
    output logic       ZERO
);
    logic [7:0] b_x;
    logic       c8;
    assign b_x = B ^ {8{sub}};
    assign {c8, Sum} = {1'b0, A} + {1'b0, b_x} + {8'b0, sub};
    assign Cout = c8 ^ sub;
    assign Ovf  = (A[7] == b_x[7]) && (Sum[7] != A[7]);
    assign ZERO = Sum == 8'h00;
endmodule

// File: rtl/acc_exec_unit.sv
// acc_exec_unit: command FSM holding accumulator, B register and C/V/Z flags around the ALU
module acc_exec_unit
    import acc_exec_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    acc_exec_if.slave  bus,
    output logic [7:0] acc,
    output logic       flag_c,
    output logic       flag_v,
    output logic       flag_z,
    output logic       busy
);
    state_e     state_q;
    logic [2:0] op_q;
    logic [7:0] data_q, acc_q, breg_q, out_data_q;
    logic       c_q, v_q, z_q, out_valid_q;
    logic [7:0] sum;
    logic       cout, ovf, zero;

    ALU u_alu (
        .A    (acc_q),
        .B    (op_q == OP_ADDI ? data_q : breg_q),
        .sub  (op_q == OP_SUB || op_q == OP_CMP),
        .Sum  (sum),
        .Cout (cout),
        .Ovf  (ovf),
        .ZERO (zero)
    );

    assign bus.cmd_ready = state_q == IDLE && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign acc    = acc_q;
    assign flag_c = c_q;
    assign flag_v = v_q;
    assign flag_z = z_q;
    assign busy   = state_q != IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= OP_NOP;
            data_q      <= 8'h00;
            acc_q       <= ACC_RESET;
            breg_q      <= 8'h00;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            z_q         <= 1'b0;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.cmd_valid) begin
                    op_q   <= bus.cmd_op;
                    data_q <= bus.cmd_data;
                    if (bus.cmd_op == OP_OUT) begin
                        out_data_q  <= acc_q;
                        out_valid_q <= 1'b1;
                        state_q     <= EMIT;
                    end else if (bus.cmd_op != OP_NOP) begin
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    state_q <= IDLE;
                    case (op_q)
                        OP_LDA: begin
                            acc_q <= data_q;
                            z_q   <= data_q == 8'h00;
                        end
                        OP_LDB: breg_q <= data_q;
                        OP_ADD, OP_SUB, OP_ADDI: begin
                            acc_q <= sum;
                            c_q   <= cout;
                            v_q   <= ovf;
                            z_q   <= zero;
                        end
                        OP_CMP: begin
                            c_q <= cout;
                            v_q <= ovf;
                            z_q <= zero;
                        end
                        default: ;
                    endcase
                end
                EMIT: if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_acc_exec_unit.sv
// tb_acc_exec_unit: directed commands with a scoreboard monitor for write-backs and emitted data
module tb_acc_exec_unit;
    import acc_exec_pkg::*;

    typedef struct packed {
        logic [7:0] a;
        logic       c;
        logic       v;
        logic       z;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] acc;
    logic       flag_c, flag_v, flag_z, busy;
    int         checks = 0;
    int         errors = 0;
    rec_t       exp_q[$];
    logic [7:0] out_q[$];

    acc_exec_if bus ();

    acc_exec_unit dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .acc    (acc),
        .flag_c (flag_c),
        .flag_v (flag_v),
        .flag_z (flag_z),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // A write-back is due at the negedge after any EXEC cycle that was not reset.
    initial begin
        logic pend;
        rec_t e;
        logic [7:0] o;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (pend) begin
                if (exp_q.size() == 0) check("unexpected_writeback", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("acc", {24'b0, acc}, {24'b0, e.a});
                    check("flag_c", {31'b0, flag_c}, {31'b0, e.c});
                    check("flag_v", {31'b0, flag_v}, {31'b0, e.v});
                    check("flag_z", {31'b0, flag_z}, {31'b0, e.z});
                end
            end
            pend = busy && !bus.out_valid && !rst;
            if (bus.out_valid && bus.out_ready && !rst) begin
                if (out_q.size() == 0) check("unexpected_output", 1, 0);
                else begin
                    o = out_q.pop_front();
                    check("out_data", {24'b0, bus.out_data}, {24'b0, o});
                end
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [7:0] d);
        int n;
        n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = d;
        @(negedge clk);
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) check("send_timeout", 1, 0);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic exec(input logic [2:0] op, input logic [7:0] d, input logic [7:0] a,
                        input logic c, input logic v, input logic z);
        exp_q.push_back('{a, c, v, z});
        send(op, d);
        @(negedge clk);
        check("ready_low_in_exec", {31'b0, bus.cmd_ready}, 0);
        @(negedge clk);
        check("ready_after_exec", {31'b0, bus.cmd_ready}, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_NOP;
        bus.cmd_data  = 8'h00;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("ready_in_reset", {31'b0, bus.cmd_ready}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_acc", {24'b0, acc}, 0);
        check("rst_flags", {29'b0, flag_c, flag_v, flag_z}, 0);
        check("rst_ready", {31'b0, bus.cmd_ready}, 1);
        check("rst_out_valid", {31'b0, bus.out_valid}, 0);
        check("rst_out_data", {24'b0, bus.out_data}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        @(posedge clk);
        #1;
        exec(OP_LDA, 8'h7F, 8'h7F, 0, 0, 0);
        exec(OP_LDB, 8'h01, 8'h7F, 0, 0, 0);
        exec(OP_ADD, 8'h00, 8'h80, 0, 1, 0);
        exec(OP_LDA, 8'h05, 8'h05, 0, 1, 0);
        exec(OP_LDB, 8'h05, 8'h05, 0, 1, 0);
        exec(OP_CMP, 8'h00, 8'h05, 0, 0, 1);
        exec(OP_LDB, 8'h06, 8'h05, 0, 0, 1);
        exec(OP_SUB, 8'h00, 8'hFF, 1, 0, 0);
        exec(OP_LDA, 8'h01, 8'h01, 1, 0, 0);
        exec(OP_ADDI, 8'hFF, 8'h00, 1, 0, 1);
        exec(OP_LDA, 8'h00, 8'h00, 1, 0, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_NOP;
        repeat (3) begin
            @(negedge clk);
            check("nop_ready", {31'b0, bus.cmd_ready}, 1);
            check("nop_busy", {31'b0, busy}, 0);
            @(posedge clk);
            #1;
        end
        bus.cmd_valid = 1'b0;
        exec(OP_LDA, 8'h3C, 8'h3C, 1, 0, 0);
        bus.out_ready = 1'b0;
        out_q.push_back(8'h3C);
        send(OP_OUT, 8'h00);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_LDA;
        bus.cmd_data  = 8'h11;
        exp_q.push_back('{8'h11, 1'b1, 1'b0, 1'b0});
        repeat (3) begin
            @(negedge clk);
            check("bp_out_valid", {31'b0, bus.out_valid}, 1);
            check("bp_out_data", {24'b0, bus.out_data}, 8'h3C);
            check("bp_ready", {31'b0, bus.cmd_ready}, 0);
            check("bp_acc_held", {24'b0, acc}, 8'h3C);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_ready_after", {31'b0, bus.cmd_ready}, 1);
        check("bp_valid_after", {31'b0, bus.out_valid}, 0);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("bp_lda_exec", {31'b0, bus.cmd_ready}, 0);
        @(negedge clk);
        @(posedge clk);
        #1;
        out_q.push_back(8'h11);
        send(OP_OUT, 8'h00);
        @(negedge clk);
        check("emit1_valid", {31'b0, bus.out_valid}, 1);
        @(negedge clk);
        check("emit1_ready", {31'b0, bus.cmd_ready}, 1);
        check("emit1_valid_low", {31'b0, bus.out_valid}, 0);
        @(posedge clk);
        #1;
        exec(OP_LDB, 8'h01, 8'h11, 1, 0, 0);
        send(OP_ADD, 8'h00);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_exec_acc", {24'b0, acc}, {24'b0, ACC_RESET});
        check("rst_exec_flags", {29'b0, flag_c, flag_v, flag_z}, 0);
        check("rst_exec_busy", {31'b0, busy}, 0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        send(OP_OUT, 8'h00);
        @(negedge clk);
        check("rst_emit_pre", {31'b0, bus.out_valid}, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_emit_valid", {31'b0, bus.out_valid}, 0);
        check("rst_emit_busy", {31'b0, busy}, 0);
        check("rst_emit_ready", {31'b0, bus.cmd_ready}, 1);
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("exp_q_drained", exp_q.size(), 0);
        check("out_q_drained", out_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
